// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample width and the complex bin type.
// Imported by the FFT core and by its downstream consumers.
package fft_pkg;
  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_DW    = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx16_t;
endpackage

// File: rtl/cplx_mag2.sv
// Two-stage |X|^2 pipeline: S1 squares each component, S2 sums them.
// Valid and bin index travel alongside the data.
module cplx_mag2
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int IW = FFT_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IW-1:0]        in_idx,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic                 out_valid,
  output logic [IW-1:0]        out_idx,
  output logic [2*DW-1:0]      pow
);
  localparam int PW = 2*DW;

  logic [2:1]           vld_pipe;
  logic signed [PW-1:0] sq_r, sq_i;
  logic [IW-1:0]        idx1;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[1], in_valid};
  end

  // Squares are non-negative and their sum is at most 2^(2*DW-1): no overflow.
  always_ff @(posedge clk) begin
    sq_r    <= PW'(din_r) * PW'(din_r);
    sq_i    <= PW'(din_i) * PW'(din_i);
    idx1    <= in_idx;
    pow     <= $unsigned(sq_r) + $unsigned(sq_i);
    out_idx <= idx1;
  end

  assign out_valid = vld_pipe[2];
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame spectral peak detector: strongest bin, its power, total energy and
// a threshold flag, one result pulse per 64-bin frame, no backpressure.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int              DW      = FFT_DW,
  parameter int              LOG2N   = FFT_LOG2N,
  parameter logic [2*DW-1:0] THRESH  = '0,
  parameter bit              SKIP_DC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [DW-1:0]  din_r,
  input  logic signed [DW-1:0]  din_i,
  output logic                  out_valid,
  output logic [LOG2N-1:0]      peak_bin,
  output logic [2*DW-1:0]       peak_pow,
  output logic [2*DW+LOG2N-1:0] frame_energy,
  output logic                  over_thresh
);
  localparam int PW = 2*DW;
  localparam int EW = PW + LOG2N;

  logic [LOG2N-1:0] idx;
  logic             s2_valid;
  logic [LOG2N-1:0] s2_idx;
  logic [PW-1:0]    s2_pow;

  logic [PW-1:0]    run_max, nxt_max;
  logic [LOG2N-1:0] run_bin, nxt_bin;
  logic [EW-1:0]    run_en,  nxt_en;

  always_ff @(posedge clk) begin
    if (rst)           idx <= '0;
    else if (in_valid) idx <= idx + LOG2N'(1);
  end

  cplx_mag2 #(.DW(DW), .IW(LOG2N)) u_mag2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_idx   (idx),
    .din_r    (din_r),
    .din_i    (din_i),
    .out_valid(s2_valid),
    .out_idx  (s2_idx),
    .pow      (s2_pow)
  );

  // Bin 0 restarts the frame; with DC skipped the search seeds at bin 1 / power 0
  // so an all-zero frame reports bin 1. Strict '>' keeps the lowest index on ties.
  always_comb begin
    nxt_max = run_max;
    nxt_bin = run_bin;
    nxt_en  = run_en + EW'(s2_pow);
    if (s2_idx == '0) begin
      nxt_en  = EW'(s2_pow);
      nxt_max = SKIP_DC ? '0 : s2_pow;
      nxt_bin = SKIP_DC ? LOG2N'(1) : '0;
    end else if (s2_pow > run_max) begin
      nxt_max = s2_pow;
      nxt_bin = s2_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max      <= '0;
      run_bin      <= '0;
      run_en       <= '0;
      out_valid    <= 1'b0;
      peak_bin     <= '0;
      peak_pow     <= '0;
      frame_energy <= '0;
      over_thresh  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s2_valid) begin
        run_max <= nxt_max;
        run_bin <= nxt_bin;
        run_en  <= nxt_en;
        if (&s2_idx) begin
          peak_bin     <= nxt_bin;
          peak_pow     <= nxt_max;
          frame_energy <= nxt_en;
          over_thresh  <= (nxt_max > THRESH);
          out_valid    <= 1'b1;
        end
      end
    end
  end
endmodule
